// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices and FSM encoding.
package pipeline_pkg;

    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IFID  = 1;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 3;
    localparam int unsigned STG_MEMWB = 4;
    localparam int unsigned NUM_STG   = 5;
    localparam int unsigned ADDR_W    = 32;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_REDIR_WAIT = 2'd1,
        ST_EXC_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } hz_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_stall_decode.sv
// Priority stall rule: the oldest busy stage freezes itself and everything younger,
// and a bubble is injected into the register just downstream of it.
module hazard_stall_decode
    import pipeline_pkg::*;
(
    input  logic               if_busy_i,
    input  logic               load_use_i,
    input  logic               div_busy_i,
    input  logic               mem_busy_i,
    output logic [NUM_STG-1:0] we_c,
    output logic [NUM_STG-1:0] clr_c
);

    always_comb begin
        we_c  = 5'b11111;
        clr_c = 5'b00000;
        if (mem_busy_i) begin
            we_c  = 5'b00000;
            clr_c = 5'b10000;
        end else if (div_busy_i) begin
            we_c  = 5'b10000;
            clr_c = 5'b01000;
        end else if (load_use_i) begin
            we_c  = 5'b11000;
            clr_c = 5'b00100;
        end else if (if_busy_i) begin
            we_c  = 5'b11100;
            clr_c = 5'b00010;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stall rule, pending redirects and
// exceptions held until fetch is idle, MEM bus timeout watch and a stall counter.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_busy,
    input  logic              load_use,
    input  logic              div_busy,
    input  logic              mem_busy,
    input  logic              redir_req,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic              exc_req,
    input  logic [ADDR_W-1:0] exc_pc,
    output logic [4:0]        reg_we,
    output logic [4:0]        reg_clr,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic              bus_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned TOW = $clog2(MEM_TIMEOUT + 1);

    hz_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  redir_lat_q, redir_lat_d;
    logic [ADDR_W-1:0]  exc_lat_q, exc_lat_d;
    logic [FCW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [TOW-1:0]     tmo_q, tmo_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [NUM_STG-1:0] stall_we_c, stall_clr_c;
    logic               flush_last_c;

    hazard_stall_decode u_stall_decode (
        .if_busy_i  (if_busy),
        .load_use_i (load_use),
        .div_busy_i (div_busy),
        .mem_busy_i (mem_busy),
        .we_c       (stall_we_c),
        .clr_c      (stall_clr_c)
    );

    assign flush_last_c = (32'(flush_cnt_q) == FLUSH_CYCLES - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            redir_lat_q <= '0;
            exc_lat_q   <= '0;
            flush_cnt_q <= '0;
            tmo_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            redir_lat_q <= redir_lat_d;
            exc_lat_q   <= exc_lat_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_q       <= tmo_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state and per-register write/clear controls; exceptions override every state.
    always_comb begin
        state_d      = state_q;
        redir_lat_d  = redir_lat_q;
        exc_lat_d    = exc_lat_q;
        flush_cnt_d  = flush_cnt_q;
        reg_we       = stall_we_c;
        reg_clr      = stall_clr_c;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        if (exc_req) begin
            reg_we[STG_PC] = 1'b0;
            reg_clr        = 5'b11110;
            exc_lat_d      = exc_pc;
            flush_cnt_d    = '0;
            state_d        = if_busy ? ST_EXC_WAIT : ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (redir_req) begin
                        if (stall_we_c[STG_PC]) begin
                            pc_load      = 1'b1;
                            pc_load_addr = redir_pc;
                        end else begin
                            redir_lat_d = redir_pc;
                            state_d     = ST_REDIR_WAIT;
                        end
                    end
                end
                ST_REDIR_WAIT: begin
                    if (redir_req) begin
                        redir_lat_d = redir_pc;
                    end
                    if (stall_we_c[STG_PC]) begin
                        pc_load      = 1'b1;
                        pc_load_addr = redir_req ? redir_pc : redir_lat_q;
                        state_d      = ST_RUN;
                    end
                end
                ST_EXC_WAIT: begin
                    reg_we  = 5'b00000;
                    reg_clr = 5'b01110;
                    if (!if_busy) begin
                        flush_cnt_d = '0;
                        state_d     = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    reg_we  = {stall_we_c[STG_MEMWB], 3'b111, (flush_cnt_q == '0)};
                    reg_clr = {stall_clr_c[STG_MEMWB], 3'b111, 1'b0};
                    if (flush_cnt_q == '0) begin
                        pc_load      = 1'b1;
                        pc_load_addr = exc_lat_q;
                    end
                    if (flush_last_c) begin
                        flush_cnt_d = '0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FCW'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Consecutive mem_busy watchdog; the stall itself is left to the stall rule.
    always_comb begin
        bus_timeout = mem_busy && ((32'(tmo_q) + 32'd1) == MEM_TIMEOUT);
        tmo_d       = (!mem_busy || bus_timeout) ? '0 : tmo_q + TOW'(1);
    end

    assign stall_cnt_d = reg_we[STG_PC] ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    assign stall_cnt   = stall_cnt_q;

endmodule
